cv_ctrl_port: RTL and testbench

//  Console-side end of the two ColecoVision controller ports. Holds the keypad/joystick

---
 rtl/cv_ctrl_pkg.sv | 31 +++
 rtl/cv_ctrl_p9_filter.sv | 57 +++++
 rtl/cv_ctrl_port.sv | 105 ++++++++++
 tb/tb_cv_ctrl_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// Shared types and read-byte layout for the ColecoVision controller port block.
package cv_ctrl_pkg;

    typedef enum logic {
        KEYPAD   = 1'b0,
        JOYSTICK = 1'b1
    } mode_t;

    localparam int D_P1 = 0;
    localparam int D_P2 = 1;
    localparam int D_P3 = 2;
    localparam int D_P4 = 3;
    localparam int D_P7 = 4;
    localparam int D_P6 = 6;
    localparam logic [7:0] D_IDLE = 8'hFF;

    // Unused bits 5 and 7 read back as 1, matching the idle bus level.
    function automatic logic [7:0] read_byte(input logic p1, input logic p2, input logic p3,
                                             input logic p4, input logic p6, input logic p7);
        logic [7:0] b;
        b       = D_IDLE;
        b[D_P1] = p1;
        b[D_P2] = p2;
        b[D_P3] = p3;
        b[D_P4] = p4;
        b[D_P6] = p6;
        b[D_P7] = p7;
        return b;
    endfunction

endpackage

// File: rtl/cv_ctrl_p9_filter.sv
// Spinner pulse conditioning: synchroniser, stability counter, falling-edge pulse.
module cv_ctrl_p9_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int P9_FILTER   = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clk_en_i,
    input  logic p9_i,
    output logic fall_o
);

    localparam int CW = $clog2(P9_FILTER) + 1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   p9_sync;
    logic                   level_reg;
    logic [CW-1:0]          cnt_reg;
    logic [CW-1:0]          cnt_next;
    logic                   level_next;
    logic                   mismatch;
    logic                   accept;

    assign p9_sync  = sync_reg[SYNC_STAGES-1];
    assign mismatch = (p9_sync != level_reg);
    // The sample that completes the run is accepted in the same cycle it is seen.
    assign accept   = clk_en_i && mismatch && (cnt_reg == CW'(P9_FILTER - 1));
    assign fall_o   = accept && !p9_sync;

    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        if (clk_en_i) begin
            if (!mismatch) begin
                cnt_next = '0;
            end else if (accept) begin
                cnt_next   = '0;
                level_next = p9_sync;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_reg  <= '1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], p9_i};
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/cv_ctrl_port.sv
// Console-side controller ports: segment select strobes, input sync, CPU read byte, spinner IRQ.
module cv_ctrl_port
    import cv_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int P9_FILTER   = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clk_en_i,
    input  logic       key_sel_wr_i,
    input  logic       joy_sel_wr_i,
    input  logic       rd_i,
    input  logic       rd_port_i,
    output logic [7:0] d_o,
    output logic       int_n_o,
    input  logic [1:0] ctrl_p1_i,
    input  logic [1:0] ctrl_p2_i,
    input  logic [1:0] ctrl_p3_i,
    input  logic [1:0] ctrl_p4_i,
    input  logic [1:0] ctrl_p6_i,
    input  logic [1:0] ctrl_p7_i,
    input  logic [1:0] ctrl_p9_i,
    output logic [1:0] ctrl_p5_o,
    output logic [1:0] ctrl_p8_o
);

    logic [11:0]                  raw_lines;
    logic [SYNC_STAGES-1:0][11:0] sync_reg;
    logic [11:0]                  sync_lines;
    logic [7:0]                   port_byte [2];
    logic [1:0]                   fall;
    mode_t                        mode_reg;
    mode_t                        mode_next;
    logic [7:0]                   d_reg;
    logic [1:0]                   pend_reg;
    logic [1:0]                   pend_next;
    logic                         int_n_reg;

    // Two bits per line, bit 0 = port 1, bit 1 = port 2.
    assign raw_lines  = {ctrl_p7_i, ctrl_p6_i, ctrl_p4_i, ctrl_p3_i, ctrl_p2_i, ctrl_p1_i};
    assign sync_lines = sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_byte[gi] = read_byte(sync_lines[gi],     sync_lines[2 + gi],
                                             sync_lines[4 + gi], sync_lines[6 + gi],
                                             sync_lines[8 + gi], sync_lines[10 + gi]);

            cv_ctrl_p9_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .P9_FILTER   (P9_FILTER)
            ) u_p9_filter (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .clk_en_i  (clk_en_i),
                .p9_i      (ctrl_p9_i[gi]),
                .fall_o    (fall[gi])
            );
        end
    endgenerate

    always_comb begin
        mode_next = mode_reg;
        if (key_sel_wr_i) begin
            mode_next = KEYPAD;
        end else if (joy_sel_wr_i) begin
            mode_next = JOYSTICK;
        end
    end

    // A new edge overrides a same-cycle acknowledging read so no interrupt is lost.
    always_comb begin
        pend_next = pend_reg;
        if (rd_i) begin
            pend_next[rd_port_i] = 1'b0;
        end
        pend_next = pend_next | fall;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_reg  <= '1;
            mode_reg  <= KEYPAD;
            d_reg     <= D_IDLE;
            pend_reg  <= '0;
            int_n_reg <= 1'b1;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw_lines};
            mode_reg  <= mode_next;
            pend_reg  <= pend_next;
            int_n_reg <= ~|pend_next;
            if (rd_i) begin
                d_reg <= port_byte[rd_port_i];
            end
        end
    end

    assign d_o       = d_reg;
    assign int_n_o   = int_n_reg;
    assign ctrl_p5_o = {2{mode_reg == JOYSTICK}};
    assign ctrl_p8_o = {2{mode_reg == KEYPAD}};

endmodule

// File: tb/tb_cv_ctrl_port.sv
// Self-checking bench for cv_ctrl_port: directed table, corner sequences, random vs. model.
module tb_cv_ctrl_port;

    localparam int SYNC = 2;
    localparam int FILT = 4;

    typedef struct packed {
        logic [1:0] p1, p2, p3, p4, p6, p7, p9;
    } lines_t;

    typedef struct {
        logic       key, joy, rd, port;
        lines_t     l;
        logic [1:0] exp_p5, exp_p8;
        logic [7:0] exp_d;
        logic       exp_int;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       clk_en_i, key_sel_wr_i, joy_sel_wr_i, rd_i, rd_port_i;
    logic [7:0] d_o;
    logic       int_n_o;
    logic [1:0] ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i, ctrl_p7_i, ctrl_p9_i;
    logic [1:0] ctrl_p5_o, ctrl_p8_o;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Behavioural model state
    bit         mode_m;
    logic [7:0] d_m;
    logic [1:0] pend_m;
    logic [1:0] acc_m;
    int         run_m [2];
    lines_t     hist [$];

    always #5 clk_i = ~clk_i;

    cv_ctrl_port #(.SYNC_STAGES(SYNC), .P9_FILTER(FILT)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .clk_en_i     (clk_en_i),
        .key_sel_wr_i (key_sel_wr_i),
        .joy_sel_wr_i (joy_sel_wr_i),
        .rd_i         (rd_i),
        .rd_port_i    (rd_port_i),
        .d_o          (d_o),
        .int_n_o      (int_n_o),
        .ctrl_p1_i    (ctrl_p1_i),
        .ctrl_p2_i    (ctrl_p2_i),
        .ctrl_p3_i    (ctrl_p3_i),
        .ctrl_p4_i    (ctrl_p4_i),
        .ctrl_p6_i    (ctrl_p6_i),
        .ctrl_p7_i    (ctrl_p7_i),
        .ctrl_p9_i    (ctrl_p9_i),
        .ctrl_p5_o    (ctrl_p5_o),
        .ctrl_p8_o    (ctrl_p8_o)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (txn %0d)", name, act, exp, txn);
        end
    endtask

    function automatic void model_reset();
        mode_m = 1'b0;
        d_m    = 8'hFF;
        pend_m = 2'b00;
        acc_m  = 2'b11;
        run_m  = '{0, 0};
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('1);
    endfunction

    // One clock edge: lines seen by the logic are those driven SYNC edges earlier.
    function automatic void model_edge(input logic key, input logic joy, input logic rd,
                                       input logic port, input logic en, input lines_t cur);
        lines_t     s;
        logic [1:0] fall;
        int         p;
        s = hist[0];
        void'(hist.pop_front());
        hist.push_back(cur);
        if (key) mode_m = 1'b0;
        else if (joy) mode_m = 1'b1;
        fall = 2'b00;
        for (int n = 0; n < 2; n++) begin
            if (en) begin
                if (s.p9[n] != acc_m[n]) begin
                    run_m[n]++;
                    if (run_m[n] >= FILT) begin
                        acc_m[n] = s.p9[n];
                        run_m[n] = 0;
                        if (s.p9[n] == 1'b0) fall[n] = 1'b1;
                    end
                end else begin
                    run_m[n] = 0;
                end
            end
        end
        p = int'(port);
        if (rd) begin
            d_m = {1'b1, s.p6[p], 1'b1, s.p7[p], s.p4[p], s.p3[p], s.p2[p], s.p1[p]};
            pend_m[p] = 1'b0;
        end
        pend_m = pend_m | fall;
    endfunction

    task automatic cycle(input logic key, input logic joy, input logic rd, input logic port,
                         input logic en, input lines_t l);
        @(negedge clk_i);
        key_sel_wr_i = key;
        joy_sel_wr_i = joy;
        rd_i         = rd;
        rd_port_i    = port;
        clk_en_i     = en;
        ctrl_p1_i = l.p1; ctrl_p2_i = l.p2; ctrl_p3_i = l.p3; ctrl_p4_i = l.p4;
        ctrl_p6_i = l.p6; ctrl_p7_i = l.p7; ctrl_p9_i = l.p9;
        @(posedge clk_i);
        model_edge(key, joy, rd, port, en, l);
        #1;
        chk("model_p5", {6'b0, ctrl_p5_o}, {6'b0, mode_m ? 2'b11 : 2'b00});
        chk("model_p8", {6'b0, ctrl_p8_o}, {6'b0, mode_m ? 2'b00 : 2'b11});
        chk("model_d", d_o, d_m);
        chk("model_int", {7'b0, int_n_o}, {7'b0, ~|pend_m});
        txn++;
        $display("txn %0d key=%b joy=%b rd=%b port=%b en=%b p9=%b -> p5=%b p8=%b d=%h int_n=%b",
                 txn, key, joy, rd, port, en, l.p9, ctrl_p5_o, ctrl_p8_o, d_o, int_n_o);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        key_sel_wr_i = 1'b0; joy_sel_wr_i = 1'b0; rd_i = 1'b0; rd_port_i = 1'b0; clk_en_i = 1'b0;
        ctrl_p1_i = '1; ctrl_p2_i = '1; ctrl_p3_i = '1; ctrl_p4_i = '1;
        ctrl_p6_i = '1; ctrl_p7_i = '1; ctrl_p9_i = '1;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        model_reset();
        #1;
    endtask

    lines_t ones, pat, lw;
    vec_t   tbl [11];

    initial begin
        ones = '1;
        // Port 2: p1=1 p2=0 p3=1 p4=0 p6=0 p7=1 -> B5; port 1 all high -> FF
        pat = '{p1: 2'b11, p2: 2'b01, p3: 2'b11, p4: 2'b01, p6: 2'b01, p7: 2'b11, p9: 2'b11};

        tbl[0]  = '{0, 0, 0, 0, ones, 2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[1]  = '{0, 1, 0, 0, ones, 2'b11, 2'b00, 8'hFF, 1'b1};
        tbl[2]  = '{0, 0, 0, 0, ones, 2'b11, 2'b00, 8'hFF, 1'b1};
        tbl[3]  = '{1, 1, 0, 0, ones, 2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[4]  = '{0, 0, 0, 0, pat,  2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[5]  = '{0, 0, 0, 0, pat,  2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[6]  = '{0, 0, 0, 0, pat,  2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[7]  = '{0, 0, 1, 1, pat,  2'b00, 2'b11, 8'hB5, 1'b1};
        tbl[8]  = '{0, 0, 1, 0, pat,  2'b00, 2'b11, 8'hFF, 1'b1};
        tbl[9]  = '{0, 1, 0, 0, pat,  2'b11, 2'b00, 8'hFF, 1'b1};
        tbl[10] = '{0, 0, 1, 1, pat,  2'b11, 2'b00, 8'hB5, 1'b1};

        reset_n_i = 1'b0;
        do_reset();
        chk("reset_p5", {6'b0, ctrl_p5_o}, 8'h00);
        chk("reset_p8", {6'b0, ctrl_p8_o}, 8'h03);
        chk("reset_d", d_o, 8'hFF);
        chk("reset_int", {7'b0, int_n_o}, 8'h01);

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].key, tbl[i].joy, tbl[i].rd, tbl[i].port, 1'b1, tbl[i].l);
            chk("tbl_p5", {6'b0, ctrl_p5_o}, {6'b0, tbl[i].exp_p5});
            chk("tbl_p8", {6'b0, ctrl_p8_o}, {6'b0, tbl[i].exp_p8});
            chk("tbl_d", d_o, tbl[i].exp_d);
            chk("tbl_int", {7'b0, int_n_o}, {7'b0, tbl[i].exp_int});
        end

        // Port 1 P9 held low: accepted on the FILT-th enabled sample after sync delay
        do_reset();
        lw = ones; lw.p9 = 2'b10;
        for (int i = 0; i < SYNC + FILT - 1; i++) cycle(0, 0, 0, 0, 1, lw);
        chk("p9_not_yet", {7'b0, int_n_o}, 8'h01);
        cycle(0, 0, 0, 0, 1, lw);
        chk("p9_hold_irq", {7'b0, int_n_o}, 8'h00);

        // Glitch one sample short of the filter length
        do_reset();
        for (int i = 0; i < FILT - 1; i++) cycle(0, 0, 0, 0, 1, lw);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, ones);
        chk("p9_glitch", {7'b0, int_n_o}, 8'h01);

        // Both ports pending: interrupt holds until both are read
        do_reset();
        lw = ones; lw.p9 = 2'b00;
        for (int i = 0; i < SYNC + FILT; i++) cycle(0, 0, 0, 0, 1, lw);
        chk("both_pend", {7'b0, int_n_o}, 8'h00);
        cycle(0, 0, 1, 0, 1, lw);
        chk("read_p1_only", {7'b0, int_n_o}, 8'h00);
        cycle(0, 0, 1, 1, 1, lw);
        chk("read_both", {7'b0, int_n_o}, 8'h01);

        // Edge coincident with a clearing read on the same port, then async reset mid-count
        do_reset();
        lw = pat; lw.p9 = 2'b10;
        cycle(0, 0, 0, 0, 1, lw);
        cycle(0, 1, 0, 0, 1, lw);
        cycle(0, 0, 1, 1, 1, lw);
        chk("pre_d", d_o, 8'hB5);
        cycle(0, 0, 0, 0, 1, lw);
        cycle(0, 0, 0, 0, 1, lw);
        cycle(0, 0, 1, 0, 1, lw);
        chk("edge_wins", {7'b0, int_n_o}, 8'h00);
        cycle(0, 0, 1, 1, 1, lw);
        chk("edge_wins_hold", {7'b0, int_n_o}, 8'h00);
        lw.p9 = 2'b11;
        for (int i = 0; i < SYNC + 1; i++) cycle(0, 0, 0, 0, 1, lw);
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_int", {7'b0, int_n_o}, 8'h01);
        chk("async_p5", {6'b0, ctrl_p5_o}, 8'h00);
        chk("async_p8", {6'b0, ctrl_p8_o}, 8'h03);
        chk("async_d", d_o, 8'hFF);
        do_reset();

        // Randomised traffic against the model
        lw = ones;
        for (int i = 0; i < 600; i++) begin
            lines_t r;
            r    = lines_t'({$urandom, $urandom});
            lw.p1 = r.p1; lw.p2 = r.p2; lw.p3 = r.p3; lw.p4 = r.p4; lw.p6 = r.p6; lw.p7 = r.p7;
            for (int n = 0; n < 2; n++)
                if ($urandom_range(0, 5) == 0) lw.p9[n] = ~lw.p9[n];
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), lw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
